// File: rtl/updown_addr_counter_pkg.sv
// Shared constants and types for the multi-byte up/down address counter.
package updown_addr_counter_pkg;

  // Default width of the shared data bus and of one counter byte lane.
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Encoding of the UP_DN input.
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Action the count register takes on the next clock edge.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_COMMIT,
    OP_INC,
    OP_DEC
  } cntOp_e;

  // Lane-select width; a single-lane counter still carries a 1-bit selector.
  function automatic int selWidth(input int numBytes);
    return (numBytes > 1) ? $clog2(numBytes) : 1;
  endfunction

endpackage

// File: rtl/tri_state_buffer.sv
// Generic tri-state driver: passes the input through when enabled, floats otherwise.
module tri_state_buffer
  import updown_addr_counter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output wire  [DATA_WIDTH-1:0] o_data
);

  assign o_data = i_en ? i_data : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/updown_addr_counter_lane.sv
// One byte lane of the address counter: a shadow byte staging a pending load,
// a snapshot byte for coherent multi-lane reads, and the lane's bus driver.
// Lane 0 reads the live count byte instead of its snapshot.
module addr_byte_lane
  import updown_addr_counter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int READ_LIVE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_stageWe,
  input  logic                  i_snapEn,
  input  logic                  i_readEn,
  input  logic [DATA_WIDTH-1:0] i_countByte,
  output logic [DATA_WIDTH-1:0] o_shadowByte,
  inout  wire  [DATA_WIDTH-1:0] io_data
);

  logic [DATA_WIDTH-1:0] r_shadow;
  logic [DATA_WIDTH-1:0] r_snap;
  logic [DATA_WIDTH-1:0] w_readByte;

  // Stage the bus byte until the top lane write commits the whole value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow <= '0;
    end else if (i_stageWe) begin
      r_shadow <= io_data;
    end
  end

  // Freeze this lane's count byte whenever lane 0 is read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap <= '0;
    end else if (i_snapEn) begin
      r_snap <= i_countByte;
    end
  end

  assign w_readByte   = (READ_LIVE != 0) ? i_countByte : r_snap;
  assign o_shadowByte = r_shadow;
  assign io_data      = i_readEn ? w_readByte : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/updown_addr_counter.sv
// Multi-byte up/down address counter loaded and read one byte lane at a time
// over a shared bus. Loads commit atomically on the top lane write; reads of the
// upper lanes come from a snapshot taken when lane 0 is read.
module updown_addr_counter
  import updown_addr_counter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_BYTES  = 2,
  parameter int SEL_W      = selWidth(NUM_BYTES)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            CS,
  input  logic                            WE,
  input  logic                            OE,
  input  logic [SEL_W-1:0]                BYTE_SEL,
  input  logic                            CNT_EN,
  input  logic                            UP_DN,
  input  logic                            OE_A,
  inout  wire  [DATA_WIDTH-1:0]           data,
  output wire  [DATA_WIDTH*NUM_BYTES-1:0] address,
  output logic                            carry,
  output logic                            borrow,
  output logic                            zero
);

  localparam int CW = DATA_WIDTH * NUM_BYTES;

  logic [CW-1:0]        r_count;
  logic                 r_carry;
  logic                 r_borrow;
  logic                 w_wrAccess;
  logic                 w_rdAccess;
  logic                 w_commit;
  logic [NUM_BYTES-1:0] w_laneSel;
  logic [CW-1:0]        w_shadowBus;
  logic [CW-1:0]        w_commitVal;
  cntOp_e               w_op;

  // A write takes priority over a read, so WE|OE together never drives the bus.
  assign w_wrAccess = CS & WE;
  assign w_rdAccess = CS & OE & ~WE;
  assign w_commit   = w_wrAccess & w_laneSel[NUM_BYTES-1];

  // One-hot lane decode; out-of-range selects match no lane and are ignored.
  always_comb begin
    w_laneSel = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      w_laneSel[k] = (BYTE_SEL == SEL_W'(k));
    end
  end

  // Committed value: top lane straight from the bus, lower lanes from their shadows.
  always_comb begin
    w_commitVal                      = w_shadowBus;
    w_commitVal[CW-1 -: DATA_WIDTH] = data;
  end

  // Next counter action; a commit overrides counting on the same edge.
  always_comb begin
    w_op = OP_HOLD;
    if (w_commit) begin
      w_op = OP_COMMIT;
    end else if (CNT_EN) begin
      w_op = (UP_DN == CNT_UP) ? OP_INC : OP_DEC;
    end
  end

  // Count register with one-cycle wrap pulses on carry and borrow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_carry  <= (w_op == OP_INC) && (r_count == {CW{1'b1}});
      r_borrow <= (w_op == OP_DEC) && (r_count == '0);
      case (w_op)
        OP_COMMIT: r_count <= w_commitVal;
        OP_INC:    r_count <= r_count + 1'b1;
        OP_DEC:    r_count <= r_count - 1'b1;
        default:   r_count <= r_count;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_BYTES; g++) begin : gLane
    addr_byte_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .READ_LIVE ((g == 0) ? 1 : 0)
    ) uLane (
      .clk         (clk),
      .reset       (reset),
      .i_stageWe   ((g < NUM_BYTES - 1) ? (w_wrAccess & w_laneSel[g]) : 1'b0),
      .i_snapEn    (w_rdAccess & w_laneSel[0]),
      .i_readEn    (w_rdAccess & w_laneSel[g]),
      .i_countByte (r_count[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_shadowByte(w_shadowBus[g*DATA_WIDTH +: DATA_WIDTH]),
      .io_data     (data)
    );
  end

  tri_state_buffer #(
    .DATA_WIDTH(CW)
  ) uAddrBuf (
    .i_en  (OE_A),
    .i_data(r_count),
    .o_data(address)
  );

  assign carry  = r_carry;
  assign borrow = r_borrow;
  assign zero   = (r_count == '0);

endmodule
